// File: rtl/pc_seq_pkg.sv
// Shared constants and FSM state type for the program-counter sequencer.
package pc_seq_pkg;

  localparam int PC_ADDR_W       = 6;
  localparam int PC_RESET_ADDR   = 0;
  localparam int PC_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/PC bus between decode/execute, the sequencer and the PC register.
interface pc_sequencer_if #(
  parameter int ADDR_W = pc_seq_pkg::PC_ADDR_W
);
  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              running;
  logic              halted;
  logic              wrap;

  modport master (
    output start, stall, branch_taken, branch_target, halt,
    input  pc_en, pc_next, pc, flush, running, halted, wrap
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, halt,
    output pc_en, pc_next, pc, flush, running, halted, wrap
  );
endinterface

// File: rtl/pc_sequencer_bubble_counter.sv
// Branch-penalty bubble counter: load, decrement, and a flag for the final bubble.
module bubble_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       last_o
);

  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  // High when the count reaches zero at the end of this cycle.
  assign last_o = (cnt_q <= 3'd1);

endmodule

// File: rtl/pc_sequencer.sv
// Next-fetch-address selection and PC write enable with stall, branch flush and halt.
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | fetching: sequential, stall or branch redirect
//   FLUSH  | bubble cycles after a taken branch, PC held at target
//   HALTED | halt decoded, waiting for start
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W       = PC_ADDR_W,
  parameter int RESET_ADDR   = PC_RESET_ADDR,
  parameter int FLUSH_CYCLES = PC_FLUSH_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] RST_PC      = ADDR_W'(RESET_ADDR);
  localparam logic [2:0]        BUBBLE_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit                HAS_BUBBLE  = (FLUSH_CYCLES > 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_next;
  logic              flush;
  logic              wrap;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_last;

  bubble_counter u_bubble (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (BUBBLE_LOAD),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  // pc_q mirrors the external PC register, so it follows the same enable/address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
    end else begin
      state_q <= state_d;
      if (pc_en) pc_q <= pc_next;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.halt)              state_d = HALTED;
        else if (bus.branch_taken) state_d = HAS_BUBBLE ? FLUSH : RUN;
      end
      FLUSH: if (cnt_last) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_en    = 1'b0;
    pc_next  = pc_q;
    flush    = 1'b0;
    wrap     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        pc_next = RST_PC;
        pc_en   = bus.start && rst;
      end
      RUN: begin
        // Halt outranks a same-cycle branch; a stall only matters on sequential fetch.
        if (bus.halt) begin
          pc_en = 1'b0;
        end else if (bus.branch_taken) begin
          pc_en    = 1'b1;
          pc_next  = bus.branch_target;
          flush    = 1'b1;
          cnt_load = 1'b1;
        end else if (!bus.stall) begin
          pc_en   = 1'b1;
          pc_next = pc_q + ADDR_W'(1);
          wrap    = &pc_q;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_en   = pc_en;
  assign bus.pc_next = pc_next;
  assign bus.pc      = pc_q;
  assign bus.flush   = flush;
  assign bus.wrap    = wrap;
  assign bus.running = (state_q == RUN) || (state_q == FLUSH);
  assign bus.halted  = (state_q == HALTED);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Front-end controller that drives the program-counter register (6-bit instruction address space). Each cycle it selects the next fetch address from reset vector, sequential increment or branch target, and generates the PC write enable. It also handles hazard stalls, the branch-redirect flush window, and halt/start control. It sits between decode/execute control and the PC register. Its pc_en/pc_next outputs connect directly to the PC register's enable and address-in inputs.

Parameters:
ADDR_W, 6, instruction address width; all address arithmetic is modulo 2^ADDR_W.
RESET_ADDR, 0, fetch address loaded on start.
FLUSH_CYCLES, 2, bubble cycles inserted after a taken branch; legal range 1..7.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  leave IDLE/HALTED and begin fetching at RESET_ADDR
stall  in  1  hazard stall; hold PC
branch_taken  in  1  redirect request from execute
branch_target  in  ADDR_W  redirect address
halt  in  1  halt instruction decoded
pc_en  out  1  PC register write enable
pc_next  out  ADDR_W  PC register address-in
pc  out  ADDR_W  internal copy of current PC
flush  out  1  squash IF/ID pipeline registers
running  out  1  high in RUN or FLUSH
halted  out  1  high in HALTED
wrap  out  1  sequential increment wraps from max address to 0 this cycle

Behaviour:
- Registered state: FSM state {IDLE, RUN, FLUSH, HALTED}, pc_q, 3-bit bubble counter. All other outputs are combinational from state and inputs (Mealy).
- pc = pc_q. On a rising edge with pc_en=1, pc_q <= pc_next. The PC register sees the same pc_en/pc_next, so both copies stay equal.
- rst=0, asynchronous, also mid-operation: state=IDLE, pc_q=RESET_ADDR, counter=0. Outputs are then pc_en=0, pc_next=RESET_ADDR, flush=0, running=0, halted=0, wrap=0.
- IDLE:
  - start=1: pc_en=1, pc_next=RESET_ADDR, next state RUN.
  - Otherwise pc_en=0. All other inputs are ignored.
- RUN, priority halt > branch_taken > stall > sequential:
  - halt: pc_en=0, next state HALTED.
  - branch_taken: pc_en=1, pc_next=branch_target, flush=1 this cycle, counter <= FLUSH_CYCLES-1. Next state FLUSH, or RUN if FLUSH_CYCLES=1.
  - stall: pc_en=0, PC held.
  - else: pc_en=1, pc_next=pc_q+1 (truncated to ADDR_W). wrap=1 when pc_q=2^ADDR_W-1.
  - start is ignored in RUN.
- FLUSH:
  - flush=1, pc_en=0, PC held at the target. branch_taken and stall are ignored (wrong-path/bubble).
  - Counter decrements each cycle; when it is 0, the next state is RUN.
  - halt is ignored in FLUSH; it is a wrong-path instruction.
- Branch penalty: the cycle with flush=1 and the target load, plus FLUSH_CYCLES-1 hold cycles. After that, sequential fetch resumes from target+1.
- HALTED:
  - halted=1, pc_en=0, running=0.
  - start=1 behaves as in IDLE: load RESET_ADDR, next state RUN.
- branch_target equal to the current PC is legal and is treated as a normal redirect.
- wrap is asserted only on a sequential increment, never on a branch to 0.

Decomposition:
- Package pc_seq_pkg holds:
  - ADDR_W default constant;
  - RESET_ADDR default constant;
  - the seq_state_t enum {IDLE, RUN, FLUSH, HALTED}, shared with control and the bench.
- Optional sub-module bubble_counter (load, decrement, zero flag). Otherwise a single module.
- The PC register remains a separate sibling instance; pc_sequencer does not instantiate it.

Test Plan:
- Reset then idle: hold rst=0, release, 3 cycles with no start -> pc_en=0, pc=0, running=0. Assert rst=0 asynchronously between edges -> outputs reset immediately.
- Sequential fetch: start pulse, then 5 cycles -> pc sequence 0,1,2,3,4,5 and pc_en=1 every cycle.
- Stall: stall=1 for 2 cycles at pc=3 -> pc_en=0, pc stays 3. After release, pc=4 next edge.
- Branch: branch_taken=1, target=0x20 at pc=5 with FLUSH_CYCLES=2 -> flush=1 for 2 cycles, pc=0x20 after first edge, pc_en=0 on second cycle, then pc=0x21. A branch_taken pulse during the second cycle is ignored.
- Wrap and priority:
  - Run to pc=63 -> pc_next=0, wrap=1 for one cycle.
  - halt=1 together with branch_taken=1 in RUN -> halted=1, pc held, flush=0.
- Restart after halt, and reset mid-flush:
  - In HALTED, a start pulse -> pc=RESET_ADDR, running=1.
  - rst=0 during FLUSH -> state IDLE, flush=0, pc=0.
